// File: rtl/cmc_array_sequencer_if.sv
// rtl/cmc_array_sequencer_if.sv - control/status bundle between bias control and the CMC array sequencer
// master: bias/power-management control (drives en_req, settle_cycles)
// slave : sequencer (drives cell_en, n_on, ready, off, busy, step)
interface cmc_array_sequencer_if #(
    parameter int N_CELLS = 11,
    parameter int CNT_W   = 8,
    parameter int NW      = $clog2(N_CELLS + 1)
);
    logic               en_req;
    logic [CNT_W-1:0]   settle_cycles;
    logic [N_CELLS-1:0] cell_en;
    logic [NW-1:0]      n_on;
    logic               ready;
    logic               off;
    logic               busy;
    logic               step;

    modport master (
        output en_req, settle_cycles,
        input  cell_en, n_on, ready, off, busy, step
    );

    modport slave (
        input  en_req, settle_cycles,
        output cell_en, n_on, ready, off, busy, step
    );
endinterface

// File: rtl/cmc_array_sequencer.sv
// rtl/cmc_array_sequencer.sv - staged one-cell-at-a-time enable sequencer for a CMC mirror array
// Ports:
//   clk   : sequencer clock
//   rst_n : asynchronous active-low reset, drops every cell enable at once
//   sq    : slave side of cmc_array_sequencer_if
//           in : en_req (level on/off request), settle_cycles (S, step lasts S+1 cycles)
//           out: cell_en (thermometer), n_on, ready, off, busy, step (pulse on n_on change)
module cmc_array_sequencer #(
    parameter int N_CELLS = 11,
    parameter int CNT_W   = 8,
    parameter int NW      = $clog2(N_CELLS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cmc_array_sequencer_if.slave  sq
);
    localparam logic [NW-1:0] N_MAX = NW'(N_CELLS);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [NW-1:0]      n_on_q, n_on_nxt;
    logic [CNT_W-1:0]   timer, timer_nxt;
    logic [CNT_W-1:0]   settle_q, settle_nxt;
    logic               restart;
    logic [N_CELLS-1:0] cell_en_nxt;

    always_comb begin
        state_nxt   = state;
        n_on_nxt    = n_on_q;
        timer_nxt   = timer;
        settle_nxt  = settle_q;
        restart     = 1'b0;
        cell_en_nxt = '0;

        case (state)
            S_OFF: begin
                if (sq.en_req) begin
                    state_nxt = S_UP;
                    n_on_nxt  = NW'(1);
                    restart   = 1'b1;
                end
            end
            S_UP: begin
                // A dropped request reverses straight away, even mid-settle.
                if (!sq.en_req) begin
                    state_nxt = S_DOWN;
                    n_on_nxt  = n_on_q - 1'b1;
                    restart   = 1'b1;
                end else if (timer != settle_q) begin
                    timer_nxt = timer + 1'b1;
                end else if (n_on_q != N_MAX) begin
                    n_on_nxt  = n_on_q + 1'b1;
                    restart   = 1'b1;
                end else begin
                    // Last cell has had its full settle interval.
                    state_nxt = S_ON;
                    restart   = 1'b1;
                end
            end
            S_ON: begin
                if (!sq.en_req) begin
                    state_nxt = S_DOWN;
                    n_on_nxt  = N_MAX - 1'b1;
                    restart   = 1'b1;
                end
            end
            S_DOWN: begin
                if (sq.en_req) begin
                    state_nxt = S_UP;
                    n_on_nxt  = n_on_q + 1'b1;
                    restart   = 1'b1;
                end else if (timer != settle_q) begin
                    timer_nxt = timer + 1'b1;
                end else if (n_on_q != '0) begin
                    n_on_nxt  = n_on_q - 1'b1;
                    restart   = 1'b1;
                end else begin
                    state_nxt = S_OFF;
                    restart   = 1'b1;
                end
            end
            default: begin
                state_nxt = S_OFF;
                n_on_nxt  = '0;
                restart   = 1'b1;
            end
        endcase

        // Settle value is captured once per step so mid-step edits apply to the next step.
        if (restart) begin
            timer_nxt  = '0;
            settle_nxt = sq.settle_cycles;
        end

        for (int i = 0; i < N_CELLS; i++) begin
            cell_en_nxt[i] = (32'(n_on_nxt) > i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_OFF;
            n_on_q     <= '0;
            timer      <= '0;
            settle_q   <= '0;
            sq.cell_en <= '0;
            sq.ready   <= 1'b0;
            sq.off     <= 1'b1;
            sq.busy    <= 1'b0;
            sq.step    <= 1'b0;
        end else begin
            state      <= state_nxt;
            n_on_q     <= n_on_nxt;
            timer      <= timer_nxt;
            settle_q   <= settle_nxt;
            sq.cell_en <= cell_en_nxt;
            sq.ready   <= (state_nxt == S_ON);
            sq.off     <= (state_nxt == S_OFF);
            sq.busy    <= (state_nxt == S_UP) || (state_nxt == S_DOWN);
            sq.step    <= (n_on_nxt != n_on_q);
        end
    end

    assign sq.n_on = n_on_q;
endmodule
